// File: rtl/rr_channel_arbiter.sv
// Four-requester round-robin burst arbiter driving one shared data channel to paired destinations.
// Define ARB_TIMEOUT_EN to force release of a granted requester that stalls TIMEOUT cycles.
module rr_channel_arbiter #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           in_valid,
   input  logic [4*WIDTH-1:0]   in_data,
   input  logic [3:0]           in_last,
   output logic [3:0]           in_ready,
   output logic [3:0]           out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_last,
   input  logic [3:0]           out_ready,
   output logic [1:0]           sel,
   output logic [3:0]           grant,
   output logic                 timeout_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] rrPtr_q, rrPtr_d;
   logic [1:0] winner;
   logic [1:0] idx;
   logic       xfer;
   logic       timeoutHit;

   assign xfer = (state_q == BUSY) && in_valid[sel_q] && out_ready[sel_q];

   // Scan from the highest offset down so the requester closest to rrPtr wins.
   always_comb begin
      winner = rrPtr_q;
      idx    = rrPtr_q;
      for (int k = 3; k >= 0; k--) begin
         idx = rrPtr_q + 2'(k);
         if (in_valid[idx]) begin
            winner = idx;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
   logic             timeoutErr_q, timeoutErr_d;

   always_comb begin
      stallCnt_d   = '0;
      timeoutErr_d = 1'b0;
      timeoutHit   = 1'b0;
      if (state_q == BUSY) begin
         if (stallCnt_q == CNT_W'(TIMEOUT)) begin
            timeoutHit   = 1'b1;
            timeoutErr_d = 1'b1;
         end else if (!xfer) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCnt_q   <= '0;
         timeoutErr_q <= 1'b0;
      end else begin
         stallCnt_q   <= stallCnt_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

   assign timeout_err = timeoutErr_q;
`else
   assign timeoutHit  = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      rrPtr_d = rrPtr_q;
      case (state_q)
         IDLE: begin
            if (|in_valid) begin
               state_d = BUSY;
               grant_d = 4'b0001 << winner;
               sel_d   = winner;
               rrPtr_d = winner + 2'd1;
            end
         end
         BUSY: begin
            if (timeoutHit || (xfer && in_last[sel_q])) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         rrPtr_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         rrPtr_q <= rrPtr_d;
      end
   end

   // Channel mux/demux; forced quiet during reset so nothing leaks from an abandoned burst.
   always_comb begin
      in_ready  = '0;
      out_valid = '0;
      out_data  = '0;
      out_last  = 1'b0;
      if (rst_n && (state_q == BUSY)) begin
         out_valid[sel_q] = in_valid[sel_q];
         in_ready[sel_q]  = out_ready[sel_q];
         out_data         = in_data[int'(sel_q)*WIDTH +: WIDTH];
         out_last         = in_last[sel_q];
      end
   end

   assign grant = grant_q;
   assign sel   = sel_q;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Directed testbench for rr_channel_arbiter; inputs change on the falling edge, outputs are checked 1ns later.
module tb_rr_channel_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic [3:0]  out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic [3:0]  out_ready;
   logic [1:0]  sel;
   logic [3:0]  grant;
   logic        timeout_err;

   int vectors     = 0;
   int miscompares = 0;

   rr_channel_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_last    (out_last),
      .out_ready   (out_ready),
      .sel         (sel),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic doReset();
      rst_n     = 1'b0;
      in_valid  = 4'h0;
      in_last   = 4'h0;
      out_ready = 4'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 4'hF;
      in_last   = 4'hF;
      out_ready = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (grant !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_grant got %h want 0", grant); end
      vectors++; if (sel !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_sel got %0d want 0", sel); end
      vectors++; if (out_valid !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %h want 0", out_valid); end
      vectors++; if (in_ready !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_in_ready got %h want 0", in_ready); end
      vectors++; if (out_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_out_data got %h want 00", out_data); end
      vectors++; if (out_last !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_last got %b want 0", out_last); end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout_err got %b want 0", timeout_err); end
      in_valid = 4'h0;
      rst_n    = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_two_beat_bursts();
      logic [3:0] expGrant [12];
      logic [1:0] expSel [12];
      logic       lastSeq [12];
      logic [7:0] expData [12];
      expGrant = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4};
      expSel   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
      lastSeq  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      expData  = '{8'h00, 8'hA0, 8'hA0, 8'h00, 8'hC2, 8'hC2, 8'h00, 8'hA0, 8'hA0, 8'h00, 8'hC2, 8'hC2};
      doReset();
      in_valid  = 4'b0101;
      out_ready = 4'hF;
      for (int i = 0; i < 12; i++) begin
         in_last = {4{lastSeq[i]}};
         #1;
         vectors++; if (grant !== expGrant[i]) begin miscompares++; $display("[TB] FAIL twobeat_grant[%0d] got %h want %h", i, grant, expGrant[i]); end
         vectors++; if (sel !== expSel[i]) begin miscompares++; $display("[TB] FAIL twobeat_sel[%0d] got %0d want %0d", i, sel, expSel[i]); end
         vectors++; if (out_valid !== expGrant[i]) begin miscompares++; $display("[TB] FAIL twobeat_out_valid[%0d] got %h want %h", i, out_valid, expGrant[i]); end
         vectors++; if (in_ready !== expGrant[i]) begin miscompares++; $display("[TB] FAIL twobeat_in_ready[%0d] got %h want %h", i, in_ready, expGrant[i]); end
         vectors++; if (out_data !== expData[i]) begin miscompares++; $display("[TB] FAIL twobeat_out_data[%0d] got %h want %h", i, out_data, expData[i]); end
         vectors++; if (out_last !== ((expGrant[i] != 4'h0) && lastSeq[i])) begin miscompares++; $display("[TB] FAIL twobeat_out_last[%0d] got %b", i, out_last); end
         @(negedge clk);
      end
      in_valid = 4'h0;
   endtask

   task automatic test_round_robin();
      logic [3:0] expGrant [10];
      logic [7:0] expData [10];
      expGrant = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
      expData  = '{8'h00, 8'hA0, 8'h00, 8'hB1, 8'h00, 8'hC2, 8'h00, 8'hD3, 8'h00, 8'hA0};
      doReset();
      in_valid  = 4'hF;
      in_last   = 4'hF;
      out_ready = 4'hF;
      for (int i = 0; i < 10; i++) begin
         #1;
         vectors++; if (grant !== expGrant[i]) begin miscompares++; $display("[TB] FAIL rr_grant[%0d] got %h want %h", i, grant, expGrant[i]); end
         vectors++; if (out_data !== expData[i]) begin miscompares++; $display("[TB] FAIL rr_out_data[%0d] got %h want %h", i, out_data, expData[i]); end
         vectors++; if (out_last !== (expGrant[i] != 4'h0)) begin miscompares++; $display("[TB] FAIL rr_out_last[%0d] got %b", i, out_last); end
         @(negedge clk);
      end
      in_valid = 4'h0;
   endtask

   task automatic test_stall();
      doReset();
      in_valid  = 4'b0010;
      in_last   = 4'hF;
      out_ready = 4'h0;
      #1;
      vectors++; if (grant !== 4'h0) begin miscompares++; $display("[TB] FAIL stall_idle_grant got %h want 0", grant); end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++; if (grant !== 4'b0010) begin miscompares++; $display("[TB] FAIL stall_grant[%0d] got %h want 2", i, grant); end
         vectors++; if (out_valid !== 4'b0010) begin miscompares++; $display("[TB] FAIL stall_out_valid[%0d] got %h want 2", i, out_valid); end
         vectors++; if (out_data !== 8'hB1) begin miscompares++; $display("[TB] FAIL stall_out_data[%0d] got %h want b1", i, out_data); end
         vectors++; if (in_ready !== 4'h0) begin miscompares++; $display("[TB] FAIL stall_in_ready[%0d] got %h want 0", i, in_ready); end
         vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_timeout_err[%0d] got %b want 0", i, timeout_err); end
         @(negedge clk);
      end
      out_ready = 4'hF;
      #1;
      vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL stall_release_in_ready got %h want 2", in_ready); end
      vectors++; if (out_last !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_release_out_last got %b want 1", out_last); end
      @(negedge clk);
      out_ready = 4'h0;
      in_valid  = 4'h0;
      #1;
      vectors++; if (grant !== 4'h0) begin miscompares++; $display("[TB] FAIL stall_done_grant got %h want 0", grant); end
      vectors++; if (out_valid !== 4'h0) begin miscompares++; $display("[TB] FAIL stall_done_out_valid got %h want 0", out_valid); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_burst();
      doReset();
      in_valid  = 4'b1000;
      in_last   = 4'h0;
      out_ready = 4'hF;
      @(negedge clk);
      #1;
      vectors++; if (grant !== 4'b1000) begin miscompares++; $display("[TB] FAIL midrst_grant got %h want 8", grant); end
      vectors++; if (sel !== 2'd3) begin miscompares++; $display("[TB] FAIL midrst_sel got %0d want 3", sel); end
      vectors++; if (out_data !== 8'hD3) begin miscompares++; $display("[TB] FAIL midrst_out_data got %h want d3", out_data); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++; if (out_valid !== 4'h0) begin miscompares++; $display("[TB] FAIL midrst_gated_out_valid got %h want 0", out_valid); end
      vectors++; if (in_ready !== 4'h0) begin miscompares++; $display("[TB] FAIL midrst_gated_in_ready got %h want 0", in_ready); end
      vectors++; if (out_data !== 8'h00) begin miscompares++; $display("[TB] FAIL midrst_gated_out_data got %h want 00", out_data); end
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 4'b1010;
      #1;
      vectors++; if (grant !== 4'h0) begin miscompares++; $display("[TB] FAIL midrst_after_grant got %h want 0", grant); end
      vectors++; if (sel !== 2'd0) begin miscompares++; $display("[TB] FAIL midrst_after_sel got %0d want 0", sel); end
      vectors++; if (out_valid !== 4'h0) begin miscompares++; $display("[TB] FAIL midrst_after_out_valid got %h want 0", out_valid); end
      @(negedge clk);
      #1;
      vectors++; if (grant !== 4'b0010) begin miscompares++; $display("[TB] FAIL midrst_regrant got %h want 2", grant); end
      vectors++; if (sel !== 2'd1) begin miscompares++; $display("[TB] FAIL midrst_regrant_sel got %0d want 1", sel); end
      in_valid = 4'h0;
      @(negedge clk);
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      doReset();
      in_valid  = 4'b1100;
      in_last   = 4'h0;
      out_ready = 4'h0;
      @(negedge clk);
      for (int i = 1; i <= 17; i++) begin
         #1;
         vectors++; if (grant !== 4'b0100) begin miscompares++; $display("[TB] FAIL tmo_hold_grant[%0d] got %h want 4", i, grant); end
         vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_early_err[%0d] got %b want 0", i, timeout_err); end
         @(negedge clk);
      end
      #1;
      vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_pulse got %b want 1", timeout_err); end
      vectors++; if (grant !== 4'h0) begin miscompares++; $display("[TB] FAIL tmo_released_grant got %h want 0", grant); end
      @(negedge clk);
      #1;
      vectors++; if (grant !== 4'b1000) begin miscompares++; $display("[TB] FAIL tmo_next_grant got %h want 8", grant); end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_pulse_end got %b want 0", timeout_err); end
      in_valid = 4'h0;
      @(negedge clk);
   endtask
`else
   task automatic test_no_timeout();
      doReset();
      in_valid  = 4'b1100;
      in_last   = 4'h0;
      out_ready = 4'h0;
      @(negedge clk);
      for (int i = 1; i <= 24; i++) begin
         #1;
         vectors++; if (grant !== 4'b0100) begin miscompares++; $display("[TB] FAIL notmo_grant[%0d] got %h want 4", i, grant); end
         vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL notmo_err[%0d] got %b want 0", i, timeout_err); end
         @(negedge clk);
      end
      in_valid = 4'h0;
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'h0;
      in_last   = 4'h0;
      out_ready = 4'h0;
      in_data   = 32'hD3C2B1A0;
      @(negedge clk);
      test_reset();
      test_two_beat_bursts();
      test_round_robin();
      test_stall();
      test_reset_mid_burst();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
